fp_itof_pipe: RTL and testbench
===============================

Name: fp_itof_pipe

Overview:
Parametrised, fully pipelined integer-to-FP32 converter. It is the successor of the fixed 32-bit converter in the fp32_core. Adds configurable integer width, a per-transaction signed/unsigned mode, IEEE-754 rounding modes with an inexact flag, a tag passthrough, and a valid/ready handshake with backpressure. It sits between the issue logic and the FP writeback arbiter.

Parameters:
INT_WIDTH, 32, width of integer operand; legal range 8..64 (elaboration $fatal outside range)
TAG_WIDTH, 4, width of opaque transaction tag carried alongside the data

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous, active-low reset
in_valid  in  1  input transaction present
in_ready  out  1  converter accepts input this cycle
in_int  in  INT_WIDTH  integer operand
in_signed  in  1  1: two's-complement operand, 0: unsigned operand
in_rm  in  3  rounding mode: 000 RNE, 001 RTZ, 010 RDN, 011 RUP, 100 RMM; 101..111 treated as RNE
in_tag  in  TAG_WIDTH  tag, returned unchanged
out_valid  out  1  result present
out_ready  in  1  downstream accepts result
out_float  out  32  FP32 result
out_nx  out  1  inexact flag (result not exactly equal to operand)
out_tag  out  TAG_WIDTH  tag of this result

Behaviour:
- Reset (rst_n low, asynchronous): all stage valid bits 0, so out_valid=0. out_float=0, out_nx=0, out_tag=0. in_ready=1 after reset. Any in-flight transaction is dropped.
- Pipeline: 3 register stages. Latency is 3 cycles from an accepted input to out_valid. Throughput is 1 result per cycle.
- Handshake: advance = !out_valid | out_ready, and in_ready = advance. When advance=0, all stages hold. Bubbles are not compressed.
- A transfer occurs when valid & ready are both high on the same edge.
- out_float, out_nx and out_tag are stable while out_valid=1 and out_ready=0.
- S1 (sign/magnitude):
  - sign = in_signed & in_int[MSB].
  - mag = sign ? -in_int : in_int, unsigned INT_WIDTH bits.
  - The most negative value gives mag = 2^(INT_WIDTH-1) correctly.
  - Register sign, mag, rm and tag.
- S2 (normalise):
  - lz = leading-zero count of mag; pos = INT_WIDTH-1-lz.
  - norm = mag << lz, so the leading 1 is at the MSB.
  - Register zero = (mag==0), pos, norm, sign, rm and tag.
- S3 (round/pack):
  - Significand is norm[MSB -: 24] (hidden bit included).
  - Guard bit G = the next bit below it; sticky S = OR of all remaining bits. G=S=0 whenever pos<=23.
  - Round-up rule by mode:
    - RNE: G & (S | lsb).
    - RTZ: 0.
    - RDN: sign & (G|S).
    - RUP: !sign & (G|S).
    - RMM: G.
  - Increment the 24-bit significand. On carry-out, significand becomes 1.0 and exponent increments.
  - Exponent = pos + 127 (+1 on carry).
  - Overflow is impossible for INT_WIDTH<=64, so there is no infinity path.
  - out_nx = G|S.
- Zero: an operand of 0 yields +0 (0x00000000) with nx=0, regardless of in_signed or in_rm.
- Combinational paths: only in_ready depends combinationally on out_ready. No input-to-output data path is combinational.

Test Plan:
- Reset then stream signed 0, -1, 0x80000000 (INT_WIDTH=32, RNE), out_ready=1 -> after 3 cycles, on consecutive cycles: 0x00000000/nx0, 0xBF800000/nx0, 0xCF000000/nx0. Tags returned in order.
- Operand 16777217 (2^24+1) in RNE, RTZ, RUP, RMM -> 0x4B800000, 0x4B800000, 0x4B800001, 0x4B800001, all with nx=1. Signed -16777217 in RDN -> 0xCB800001 nx=1.
- Unsigned 0xFFFFFFFF: RNE -> 0x4F800000 nx=1 (carry into exponent); RTZ -> 0x4F7FFFFF nx=1. Same bits with in_signed=1 -> 0xBF800000 nx=0.
- Backpressure: stream 5 operands, hold out_ready=0 for 4 cycles once out_valid rises -> in_ready=0 while stalled, out_float stable, no loss or duplication, all 5 results in order after release.
- Reset mid-stream: assert rst_n=0 with 3 transactions in flight -> out_valid drops immediately (asynchronously). After release, none of the old results appear and a fresh input returns after 3 cycles.
- INT_WIDTH=64 build: unsigned 2^63+1 in RNE -> 0x5F000000 nx=1; 0xFFFFFFFFFFFFFFFF in RNE -> 0x5F800000 nx=1.

Source files
------------

// File: rtl/fp_itof_pipe.sv
// fp_itof_pipe: three-stage integer-to-FP32 converter with a valid/ready
// handshake. The stages are sign/magnitude, normalise, and round/pack.
// The whole pipeline advances together. Bubbles are kept, not squeezed out.
module fp_itof_pipe #(
    parameter int INT_WIDTH = 32,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [INT_WIDTH-1:0] in_int,
    input  logic                 in_signed,
    input  logic [2:0]           in_rm,
    input  logic [TAG_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [31:0]          out_float,
    output logic                 out_nx,
    output logic [TAG_WIDTH-1:0] out_tag
);

    if (INT_WIDTH < 8 || INT_WIDTH > 64) begin : g_bad_width
        $fatal(1, "fp_itof_pipe: INT_WIDTH must be within 8..64");
    end

    localparam int PW = $clog2(INT_WIDTH);
    // The fraction field sits above 24 zero bits, so guard and sticky always exist.
    localparam int FW = INT_WIDTH - 1 + 24;
    localparam logic [PW-1:0]        MSB_IDX = PW'(INT_WIDTH - 1);
    localparam logic [INT_WIDTH-1:0] ONE     = INT_WIDTH'(1);

    // Returns the index of the highest set bit. The result is 0 for a zero operand.
    function automatic logic [PW-1:0] msb_pos(input logic [INT_WIDTH-1:0] v);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < INT_WIDTH; i++) begin
            if (v[i]) p = PW'(i);
            else      p = p;
        end
        return p;
    endfunction

    logic                 advance_s;

    // stage 1 registers
    logic                 v1_q;
    logic                 sign1_q, sign1_d;
    logic [INT_WIDTH-1:0] mag1_q, mag1_d;
    logic [2:0]           rm1_q;
    logic [TAG_WIDTH-1:0] tag1_q;

    // stage 2 registers (the fraction field drops the leading 1)
    logic                 v2_q;
    logic                 zero2_q, zero2_d;
    logic [PW-1:0]        pos2_q, pos2_d;
    logic [INT_WIDTH-2:0] frac2_q, frac2_d;
    logic                 sign2_q;
    logic [2:0]           rm2_q;
    logic [TAG_WIDTH-1:0] tag2_q;

    // stage 3 / output registers
    logic                 v3_q;
    logic [31:0]          float3_q, float3_d;
    logic                 nx3_q, nx3_d;
    logic [TAG_WIDTH-1:0] tag3_q;

    // stage 2 and stage 3 combinational intermediates
    logic [PW-1:0]        lz_s;
    logic [INT_WIDTH-1:0] norm_s;
    logic [FW-1:0]        ext_s;
    logic [22:0]          mant_s, mant_rnd_s;
    logic                 g_s, st_s, inc_s, carry_s;
    logic [7:0]           exp_s;

    assign advance_s = ~v3_q | out_ready;
    assign in_ready  = advance_s;
    assign out_valid = v3_q;
    assign out_float = float3_q;
    assign out_nx    = nx3_q;
    assign out_tag   = tag3_q;

    // Stage 1: split the operand into sign and unsigned magnitude.
    always_comb begin
        sign1_d = in_signed & in_int[INT_WIDTH-1];
        if (sign1_d) mag1_d = (~in_int) + ONE;
        else         mag1_d = in_int;
    end

    // Stage 2: find the leading one and shift it up to the MSB.
    always_comb begin
        pos2_d  = msb_pos(mag1_q);
        lz_s    = MSB_IDX - pos2_d;
        norm_s  = mag1_q << lz_s;
        // After normalisation, only a zero magnitude has a clear MSB.
        zero2_d = ~norm_s[INT_WIDTH-1];
        frac2_d = norm_s[INT_WIDTH-2:0];
    end

    // Stage 3: round the 24-bit significand and pack the FP32 word.
    always_comb begin
        ext_s  = {frac2_q, 24'd0};
        mant_s = ext_s[FW-1 -: 23];
        g_s    = ext_s[FW-24];
        st_s   = |ext_s[FW-25:0];
        case (rm2_q)
            3'd1:    inc_s = 1'b0;                      // RTZ
            3'd2:    inc_s = sign2_q & (g_s | st_s);    // RDN
            3'd3:    inc_s = ~sign2_q & (g_s | st_s);   // RUP
            3'd4:    inc_s = g_s;                       // RMM
            default: inc_s = g_s & (st_s | mant_s[0]);  // RNE, including codes 5..7
        endcase
        // A carry out of an all-ones fraction wraps the fraction to 1.0.
        // In that case the exponent is bumped instead.
        carry_s    = inc_s & (&mant_s);
        mant_rnd_s = mant_s + {22'd0, inc_s};
        exp_s      = 8'(pos2_q) + 8'd127 + {7'd0, carry_s};
        if (zero2_q) begin
            float3_d = 32'd0;
            nx3_d    = 1'b0;
        end else begin
            float3_d = {sign2_q, exp_s, mant_rnd_s};
            nx3_d    = g_s | st_s;
        end
    end

    // Pipeline registers: every stage moves together on advance, otherwise all hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q     <= 1'b0;
            sign1_q  <= 1'b0;
            mag1_q   <= '0;
            rm1_q    <= 3'd0;
            tag1_q   <= '0;
            v2_q     <= 1'b0;
            zero2_q  <= 1'b0;
            pos2_q   <= '0;
            frac2_q  <= '0;
            sign2_q  <= 1'b0;
            rm2_q    <= 3'd0;
            tag2_q   <= '0;
            v3_q     <= 1'b0;
            float3_q <= 32'd0;
            nx3_q    <= 1'b0;
            tag3_q   <= '0;
        end else if (advance_s) begin
            v1_q     <= in_valid;
            sign1_q  <= sign1_d;
            mag1_q   <= mag1_d;
            rm1_q    <= in_rm;
            tag1_q   <= in_tag;
            v2_q     <= v1_q;
            zero2_q  <= zero2_d;
            pos2_q   <= pos2_d;
            frac2_q  <= frac2_d;
            sign2_q  <= sign1_q;
            rm2_q    <= rm1_q;
            tag2_q   <= tag1_q;
            v3_q     <= v2_q;
            float3_q <= float3_d;
            nx3_q    <= nx3_d;
            tag3_q   <= tag2_q;
        end else begin
            v1_q     <= v1_q;
            v2_q     <= v2_q;
            v3_q     <= v3_q;
        end
    end

endmodule

// File: tb/tb_fp_itof_pipe.sv
// Directed and random checks of fp_itof_pipe at INT_WIDTH=32 (dut_a) and INT_WIDTH=64 (dut_b).
// The expected values come from an arithmetic rounding model.
module tb_fp_itof_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_in_valid, a_in_ready, a_in_signed, a_out_valid, a_out_ready, a_out_nx;
    logic [31:0] a_in_int, a_out_float;
    logic [2:0]  a_in_rm;
    logic [3:0]  a_in_tag, a_out_tag;
    logic        b_in_valid, b_in_ready, b_in_signed, b_out_valid, b_out_ready, b_out_nx;
    logic [63:0] b_in_int;
    logic [31:0] b_out_float;
    logic [2:0]  b_in_rm;
    logic [3:0]  b_in_tag, b_out_tag;

    typedef struct {
        logic [31:0] f;
        logic        nx;
        logic [3:0]  tag;
    } exp_t;

    exp_t q[$];
    exp_t pend, drop;
    int   n_assert = 0;
    int   n_fail   = 0;
    int   n_pop    = 0;
    bit   acc;

    fp_itof_pipe #(.INT_WIDTH(32), .TAG_WIDTH(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .in_int(a_in_int), .in_signed(a_in_signed), .in_rm(a_in_rm), .in_tag(a_in_tag),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_float(a_out_float),
        .out_nx(a_out_nx), .out_tag(a_out_tag));

    fp_itof_pipe #(.INT_WIDTH(64), .TAG_WIDTH(4)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_int(b_in_int), .in_signed(b_in_signed), .in_rm(b_in_rm), .in_tag(b_in_tag),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_float(b_out_float),
        .out_nx(b_out_nx), .out_tag(b_out_tag));

    always #5 clk = ~clk;

    // Reference model: exact integer division into quotient and remainder.
    // Rounding is decided by comparing the remainder against one half ulp.
    function automatic void ref_conv(input logic [63:0] v, input int w, input bit sgn,
                                     input logic [2:0] rm, output logic [31:0] f,
                                     output logic nx);
        logic [63:0] mask, vm, mag, qt, rem, half;
        bit          neg, up;
        int          e;
        mask = (w == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << w) - 64'd1);
        vm   = v & mask;
        neg  = sgn && vm[w-1];
        mag  = neg ? (((~vm) + 64'd1) & mask) : vm;
        if (mag == 64'd0) begin
            f  = 32'd0;
            nx = 1'b0;
            return;
        end
        e = 63;
        while (mag[e] == 1'b0) e--;
        if (e > 23) begin
            qt   = mag >> (e - 23);
            rem  = mag & ((64'd1 << (e - 23)) - 64'd1);
            half = 64'd1 << (e - 24);
        end else begin
            qt   = mag << (23 - e);
            rem  = 64'd0;
            half = 64'd0;
        end
        case (rm)
            3'd1:    up = 1'b0;
            3'd2:    up = neg && (rem != 64'd0);
            3'd3:    up = !neg && (rem != 64'd0);
            3'd4:    up = (rem != 64'd0) && (rem >= half);
            default: up = (rem > half) || ((rem == half) && (rem != 64'd0) && qt[0]);
        endcase
        qt = qt + 64'(up);
        if (qt == (64'd1 << 24)) begin
            qt = qt >> 1;
            e++;
        end
        f  = {neg, 8'(e + 127), qt[22:0]};
        nx = (rem != 64'd0);
    endfunction

    task automatic chk(input string name, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", name, obs, expv);
        end
    endtask

    // Presents an operand to dut_a. The expected result comes from the model.
    task automatic drive(input logic [31:0] v, input bit s, input logic [2:0] rm,
                         input logic [3:0] tag);
        a_in_valid = 1'b1; a_in_int = v; a_in_signed = s; a_in_rm = rm; a_in_tag = tag;
        ref_conv({32'd0, v}, 32, s, rm, pend.f, pend.nx);
        pend.tag = tag;
    endtask

    // Presents an operand to dut_a with a fixed expected result.
    task automatic drive_c(input logic [31:0] v, input bit s, input logic [2:0] rm,
                           input logic [3:0] tag, input logic [31:0] f, input logic nx);
        a_in_valid = 1'b1; a_in_int = v; a_in_signed = s; a_in_rm = rm; a_in_tag = tag;
        pend.f = f; pend.nx = nx; pend.tag = tag;
    endtask

    // Runs one clock on dut_a. It tracks transfers in the scoreboard and checks any presented result.
    task automatic cycle(output bit accepted);
        bit pop;
        #2;
        accepted = a_in_valid && a_in_ready;
        pop      = a_out_valid && a_out_ready;
        @(posedge clk);
        #1;
        if (pop && q.size() > 0) begin
            drop = q.pop_front();
            n_pop++;
        end
        if (accepted) q.push_back(pend);
        if (a_out_valid) begin
            if (q.size() == 0) chk("spurious_valid", {63'd0, a_out_valid}, 64'd0);
            else begin
                chk("out_float", {32'd0, a_out_float}, {32'd0, q[0].f});
                chk("out_nx", {63'd0, a_out_nx}, {63'd0, q[0].nx});
                chk("out_tag", {60'd0, a_out_tag}, {60'd0, q[0].tag});
            end
        end
    endtask

    // Offers the pending operand until dut_a accepts it, within a bound.
    task automatic offer();
        bit a;
        a = 1'b0;
        for (int i = 0; i < 40 && !a; i++) cycle(a);
        chk("accept_timeout", {63'd0, a}, 64'd1);
        a_in_valid = 1'b0;
    endtask

    // Empties the dut_a pipeline with out_ready held high, within a bound.
    task automatic drain();
        bit a;
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        for (int i = 0; i < 40 && q.size() > 0; i++) cycle(a);
        chk("drain_left", 64'(q.size()), 64'd0);
        cycle(a);
        chk("idle_valid", {63'd0, a_out_valid}, 64'd0);
    endtask

    logic [63:0] b_vals[7];
    bit          b_sgn[7];
    logic [2:0]  b_rms[7];
    logic [31:0] b_f[7];
    logic        b_nx[7];

    initial begin
        rst_n = 1'b0;
        a_in_valid = 1'b0; a_in_int = 32'd0; a_in_signed = 1'b0; a_in_rm = 3'd0;
        a_in_tag = 4'd0; a_out_ready = 1'b1;
        b_in_valid = 1'b0; b_in_int = 64'd0; b_in_signed = 1'b0; b_in_rm = 3'd0;
        b_in_tag = 4'd0; b_out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", {63'd0, a_out_valid}, 64'd0);
        chk("rst_out_float", {32'd0, a_out_float}, 64'd0);
        chk("rst_out_nx", {63'd0, a_out_nx}, 64'd0);
        chk("rst_out_tag", {60'd0, a_out_tag}, 64'd0);
        chk("rst_in_ready", {63'd0, a_in_ready}, 64'd1);
        chk("rst_b_valid", {63'd0, b_out_valid}, 64'd0);
        #3 rst_n = 1'b1;

        // First stream: 0, -1 and the most negative value, all signed RNE.
        // The first result appears on the third edge and the rest follow back to back.
        drive_c(32'd0, 1'b1, 3'd0, 4'd1, 32'h0000_0000, 1'b0);
        cycle(acc);
        chk("lat_acc0", {63'd0, acc}, 64'd1);
        chk("lat_v1", {63'd0, a_out_valid}, 64'd0);
        drive_c(32'hFFFF_FFFF, 1'b1, 3'd0, 4'd2, 32'hBF80_0000, 1'b0);
        cycle(acc);
        chk("lat_v2", {63'd0, a_out_valid}, 64'd0);
        drive_c(32'h8000_0000, 1'b1, 3'd0, 4'd3, 32'hCF00_0000, 1'b0);
        cycle(acc);
        chk("lat_v3", {63'd0, a_out_valid}, 64'd1);
        a_in_valid = 1'b0;
        cycle(acc);
        chk("seq_v4", {63'd0, a_out_valid}, 64'd1);
        cycle(acc);
        chk("seq_v5", {63'd0, a_out_valid}, 64'd1);
        drain();

        // Rounding of 2^24+1 and its negation.
        drive_c(32'd16777217, 1'b0, 3'd0, 4'd4, 32'h4B80_0000, 1'b1); offer();
        drive_c(32'd16777217, 1'b0, 3'd1, 4'd5, 32'h4B80_0000, 1'b1); offer();
        drive_c(32'd16777217, 1'b0, 3'd3, 4'd6, 32'h4B80_0001, 1'b1); offer();
        drive_c(32'd16777217, 1'b0, 3'd4, 4'd7, 32'h4B80_0001, 1'b1); offer();
        drive_c(32'hFEFF_FFFF, 1'b1, 3'd2, 4'd8, 32'hCB80_0001, 1'b1); offer();
        // All-ones operand: carry into the exponent, truncation, and signed -1.
        drive_c(32'hFFFF_FFFF, 1'b0, 3'd0, 4'd9, 32'h4F80_0000, 1'b1); offer();
        drive_c(32'hFFFF_FFFF, 1'b0, 3'd1, 4'd10, 32'h4F7F_FFFF, 1'b1); offer();
        drive_c(32'hFFFF_FFFF, 1'b1, 3'd0, 4'd11, 32'hBF80_0000, 1'b0); offer();
        drive_c(32'd0, 1'b0, 3'd2, 4'd12, 32'h0000_0000, 1'b0); offer();
        drive_c(32'd3, 1'b0, 3'd7, 4'd13, 32'h4040_0000, 1'b0); offer();
        drain();

        // Backpressure: stall 4 cycles once results appear, then release.
        n_pop = 0;
        for (int i = 0; i < 3; i++) begin
            drive($urandom, 1'($urandom), 3'($urandom_range(0, 4)), 4'(i));
            cycle(acc);
            chk("bp_acc", {63'd0, acc}, 64'd1);
        end
        chk("bp_valid_rise", {63'd0, a_out_valid}, 64'd1);
        a_out_ready = 1'b0;
        drive($urandom, 1'($urandom), 3'($urandom_range(0, 4)), 4'd3);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("bp_in_ready", {63'd0, a_in_ready}, 64'd0);
            cycle(acc);
            chk("bp_no_accept", {63'd0, acc}, 64'd0);
            chk("bp_hold_valid", {63'd0, a_out_valid}, 64'd1);
        end
        a_out_ready = 1'b1;
        offer();
        drive($urandom, 1'($urandom), 3'($urandom_range(0, 4)), 4'd4);
        offer();
        drain();
        chk("bp_count", 64'(n_pop), 64'd5);

        // Asynchronous reset with three transactions in flight.
        for (int i = 0; i < 3; i++) begin
            drive($urandom, 1'b0, 3'd0, 4'(i + 8));
            cycle(acc);
        end
        a_in_valid = 1'b0;
        chk("mid_valid_before", {63'd0, a_out_valid}, 64'd1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_async_valid", {63'd0, a_out_valid}, 64'd0);
        chk("mid_async_float", {32'd0, a_out_float}, 64'd0);
        q.delete();
        @(posedge clk);
        #4 rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            chk("mid_no_old", {63'd0, a_out_valid}, 64'd0);
        end
        drive_c(32'd1, 1'b0, 3'd0, 4'd15, 32'h3F80_0000, 1'b0);
        cycle(acc);
        a_in_valid = 1'b0;
        chk("mid_fresh_v1", {63'd0, a_out_valid}, 64'd0);
        cycle(acc);
        chk("mid_fresh_v2", {63'd0, a_out_valid}, 64'd0);
        cycle(acc);
        chk("mid_fresh_v3", {63'd0, a_out_valid}, 64'd1);
        drain();

        // Random traffic with random backpressure and assorted magnitudes.
        for (int i = 0; i < 300; i++) begin
            a_out_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) != 0)
                drive($urandom >> $urandom_range(0, 31), 1'($urandom),
                      3'($urandom_range(0, 7)), 4'($urandom));
            else
                a_in_valid = 1'b0;
            cycle(acc);
        end
        drain();

        // 64-bit build: fixed cases followed by a few random operands, streamed back to back.
        b_vals[0] = 64'h8000_0000_0000_0001; b_sgn[0] = 1'b0; b_rms[0] = 3'd0;
        b_f[0] = 32'h5F00_0000; b_nx[0] = 1'b1;
        b_vals[1] = 64'hFFFF_FFFF_FFFF_FFFF; b_sgn[1] = 1'b0; b_rms[1] = 3'd0;
        b_f[1] = 32'h5F80_0000; b_nx[1] = 1'b1;
        b_vals[2] = 64'h8000_0000_0000_0000; b_sgn[2] = 1'b1; b_rms[2] = 3'd0;
        b_f[2] = 32'hDF00_0000; b_nx[2] = 1'b0;
        for (int i = 3; i < 7; i++) begin
            b_vals[i] = {$urandom, $urandom} >> $urandom_range(0, 40);
            b_sgn[i]  = 1'($urandom);
            b_rms[i]  = 3'($urandom_range(0, 4));
            ref_conv(b_vals[i], 64, b_sgn[i], b_rms[i], b_f[i], b_nx[i]);
        end
        for (int j = 0; j < 9; j++) begin
            if (j < 7) begin
                b_in_valid = 1'b1; b_in_int = b_vals[j]; b_in_signed = b_sgn[j];
                b_in_rm = b_rms[j]; b_in_tag = 4'(j);
            end else begin
                b_in_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            if (j >= 2) begin
                chk("b_valid", {63'd0, b_out_valid}, 64'd1);
                chk("b_float", {32'd0, b_out_float}, {32'd0, b_f[j-2]});
                chk("b_nx", {63'd0, b_out_nx}, {63'd0, b_nx[j-2]});
                chk("b_tag", {60'd0, b_out_tag}, 64'(j - 2));
            end
        end
        @(posedge clk);
        #1;
        chk("b_idle", {63'd0, b_out_valid}, 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
